gemm_job_arbiter: RTL

GEMM_JOB_ARBITER -- requirements
Module: gemm_job_arbiter

---
 rtl/gemm_job_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/gemm_job_arbiter.sv
// Round-robin arbiter that hands GeMM jobs from NumReq requesters to a single GeMM controller.
// Optional macro GEMM_ARB_ZERO_SKIP_EN: jobs with any zero size complete immediately without a start pulse.
module gemm_job_arbiter #(
    parameter  int unsigned NumReq    = 4,
    parameter  int unsigned AddrWidth = 16,
    localparam int unsigned IdW       = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumReq-1:0]                   req_valid_i,
    output logic [NumReq-1:0]                   req_ready_o,
    input  logic [NumReq-1:0][AddrWidth-1:0]    req_M_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]    req_K_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]    req_N_i,
    output logic [NumReq-1:0]                   cmpl_valid_o,
    output logic [IdW-1:0]                      grant_id_o,
    output logic                                busy_o,
    output logic                                gemm_start_o,
    output logic [AddrWidth-1:0]                gemm_M_size_o,
    output logic [AddrWidth-1:0]                gemm_K_size_o,
    output logic [AddrWidth-1:0]                gemm_N_size_o,
    input  logic                                gemm_done_i
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ISSUE    = 2'd1;
    localparam logic [1:0] ST_WAIT     = 2'd2;
    localparam logic [1:0] ST_COMPLETE = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [IdW-1:0]       last_grant_q, last_grant_d;
    logic [IdW-1:0]       grant_id_q, grant_id_d;
    logic [AddrWidth-1:0] m_q, m_d, k_q, k_d, n_q, n_d;
    logic [IdW-1:0]       winner_s;
    logic                 found_s;
    logic                 zero_skip_s;
    logic [NumReq-1:0]    ready_s;

    // Requester index at distance ofs after last, wrapping modulo NumReq.
    function automatic logic [IdW-1:0] rr_idx(input logic [IdW-1:0] last, input int unsigned ofs);
        int unsigned sum;
        sum = 32'(last) + ofs;
        if (sum >= NumReq) begin
            sum = sum - NumReq;
        end else begin
            sum = sum;
        end
        return IdW'(sum);
    endfunction

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        winner_s = '0;
        found_s  = 1'b0;
        for (int unsigned i = 1; i <= NumReq; i++) begin
            if (!found_s && req_valid_i[rr_idx(last_grant_q, i)]) begin
                found_s  = 1'b1;
                winner_s = rr_idx(last_grant_q, i);
            end else begin
                found_s  = found_s;
            end
        end
    end

`ifdef GEMM_ARB_ZERO_SKIP_EN
    assign zero_skip_s = (req_M_i[winner_s] == '0) || (req_K_i[winner_s] == '0) ||
                         (req_N_i[winner_s] == '0);
`else
    assign zero_skip_s = 1'b0;
`endif

    // Next-state logic; acceptance is same-cycle so ready is decoded here.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        m_d          = m_q;
        k_d          = k_q;
        n_d          = n_q;
        ready_s      = '0;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    ready_s      = NumReq'(1'b1) << winner_s;
                    last_grant_d = winner_s;
                    grant_id_d   = winner_s;
                    m_d          = req_M_i[winner_s];
                    k_d          = req_K_i[winner_s];
                    n_d          = req_N_i[winner_s];
                    state_d      = zero_skip_s ? ST_COMPLETE : ST_ISSUE;
                end else begin
                    state_d      = ST_IDLE;
                end
            end
            ST_ISSUE:    state_d = ST_WAIT;
            ST_WAIT: begin
                if (gemm_done_i) begin
                    state_d = ST_COMPLETE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_COMPLETE: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // State and latched job registers; reset makes requester 0 win first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IdW'(NumReq - 1);
            grant_id_q   <= '0;
            m_q          <= '0;
            k_q          <= '0;
            n_q          <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            m_q          <= m_d;
            k_q          <= k_d;
            n_q          <= n_d;
        end
    end

    assign req_ready_o   = ready_s;
    assign gemm_start_o  = (state_q == ST_ISSUE);
    assign busy_o        = (state_q != ST_IDLE);
    assign cmpl_valid_o  = (state_q == ST_COMPLETE) ? (NumReq'(1'b1) << last_grant_q) : '0;
    assign grant_id_o    = grant_id_q;
    assign gemm_M_size_o = m_q;
    assign gemm_K_size_o = k_q;
    assign gemm_N_size_o = n_q;

endmodule
